// File: rtl/irq_ctrl_pkg.sv
// Shared types and constants for the vectored interrupt controller:
// FSM state encoding, processor acknowledge codes and ID-width helper.
package irq_ctrl_pkg;

  typedef enum logic [1:0] {
    IDLE,
    REQ,
    SERVICE,
    WAIT_IE
  } irq_state_e;

  localparam logic [1:0] ACK_NONE  = 2'b00;
  localparam logic [1:0] ACK_TAKEN = 2'b01;
  localparam logic [1:0] ACK_RTID  = 2'b10;
  localparam logic [1:0] ACK_IE    = 2'b11;

  // A single channel still needs a 1-bit ID port.
  function automatic int id_width(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/irq_sync_edge.sv
// One interrupt channel front end: multi-flop synchroniser, polarity
// normalisation to active-high, and a registered rising-edge detect.
module irq_sync_edge #(
  parameter int   SYNC_STAGES = 2,
  parameter logic ACT_LOW     = 1'b0
) (
  input  logic i_clk,
  input  logic i_rst,
  input  logic i_async,
  output logic o_level,
  output logic o_rise
);

  logic [SYNC_STAGES-1:0] r_sync;
  logic                   r_prev;

  // Reset loads the raw inactive level so no false edge follows reset.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_sync <= {SYNC_STAGES{ACT_LOW}};
      r_prev <= 1'b0;
    end else begin
      r_sync <= {r_sync[SYNC_STAGES-2:0], i_async};
      r_prev <= o_level;
    end
  end

  assign o_level = r_sync[SYNC_STAGES-1] ^ ACT_LOW;
  assign o_rise  = o_level & ~r_prev;

endmodule

// File: rtl/irq_vector_ctrl.sv
// Vectored interrupt controller: per-channel pending/overrun latching,
// fixed lowest-index priority, and a one-in-flight acknowledge FSM.
module irq_vector_ctrl
  import irq_ctrl_pkg::*;
#(
  parameter int               N_CH         = 8,
  parameter logic [N_CH-1:0]  EDGE_MASK    = '1,
  parameter logic [N_CH-1:0]  ACT_LOW_MASK = '0,
  parameter logic [31:0]      VEC_BASE     = 32'h0000_0100,
  parameter logic [31:0]      VEC_STRIDE   = 32'h0000_0010,
  parameter int               SYNC_STAGES  = 2,
  localparam int              ID_W         = id_width(N_CH)
) (
  input  logic            sys_clk,
  input  logic            ext_rst,
  input  logic [N_CH-1:0] irq_in,
  input  logic [N_CH-1:0] irq_en,
  input  logic [N_CH-1:0] ovr_clr,
  input  logic [1:0]      intr_ack,
  output logic            intr_out,
  output logic [31:0]     intr_addr,
  output logic [ID_W-1:0] active_id,
  output logic            busy,
  output logic [N_CH-1:0] pending,
  output logic [N_CH-1:0] overrun
);

  logic [N_CH-1:0] w_level;
  logic [N_CH-1:0] w_rise;
  logic [N_CH-1:0] w_clr;
  logic [N_CH-1:0] w_ovr_set;
  logic [N_CH-1:0] w_pend_nxt;
  logic [N_CH-1:0] w_ovr_nxt;
  logic [N_CH-1:0] w_elig;
  logic            w_any;
  logic [ID_W-1:0] w_win;
  logic [31:0]     w_addr;
  irq_state_e      w_state_nxt;

  irq_state_e      r_state;
  logic            r_intr_out;
  logic [31:0]     r_addr;
  logic [ID_W-1:0] r_id;
  logic [N_CH-1:0] r_pend;
  logic [N_CH-1:0] r_ovr;

  for (genvar g = 0; g < N_CH; g++) begin : g_ch
    irq_sync_edge #(
      .SYNC_STAGES (SYNC_STAGES),
      .ACT_LOW     (ACT_LOW_MASK[g])
    ) u_sync (
      .i_clk   (sys_clk),
      .i_rst   (ext_rst),
      .i_async (irq_in[g]),
      .o_level (w_level[g]),
      .o_rise  (w_rise[g])
    );
  end

  // A rise coinciding with the ack clear re-arms pending without overrun.
  always_comb begin
    w_pend_nxt = r_pend;
    w_ovr_nxt  = r_ovr;
    w_clr      = '0;
    w_ovr_set  = '0;
    for (int i = 0; i < N_CH; i++) begin
      w_clr[i] = (r_state == REQ) && (intr_ack == ACK_TAKEN) && (r_id == ID_W'(i));
      if (EDGE_MASK[i]) begin
        w_ovr_set[i] = w_rise[i] & r_pend[i] & ~w_clr[i];
        if (w_rise[i])     w_pend_nxt[i] = 1'b1;
        else if (w_clr[i]) w_pend_nxt[i] = 1'b0;
      end else begin
        w_pend_nxt[i] = w_level[i];
      end
      if (w_ovr_set[i])    w_ovr_nxt[i] = 1'b1;
      else if (ovr_clr[i]) w_ovr_nxt[i] = 1'b0;
    end
  end

  assign w_elig = r_pend & irq_en;
  assign w_any  = |w_elig;

  always_comb begin
    w_win = '0;
    for (int i = N_CH - 1; i >= 0; i--) begin
      if (w_elig[i]) w_win = ID_W'(i);
    end
  end

  assign w_addr = VEC_BASE + 32'(w_win) * VEC_STRIDE;

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      IDLE:    if (w_any)                   w_state_nxt = REQ;
      REQ:     if (intr_ack == ACK_TAKEN)   w_state_nxt = SERVICE;
      SERVICE: if (intr_ack == ACK_RTID)    w_state_nxt = WAIT_IE;
      WAIT_IE: if (intr_ack == ACK_IE)      w_state_nxt = IDLE;
      default:                              w_state_nxt = IDLE;
    endcase
  end

  // Vector and ID are captured only on leaving IDLE, then held frozen.
  always_ff @(posedge sys_clk) begin
    if (ext_rst) begin
      r_state    <= IDLE;
      r_intr_out <= 1'b0;
      r_addr     <= VEC_BASE;
      r_id       <= '0;
      r_pend     <= '0;
      r_ovr      <= '0;
    end else begin
      r_state    <= w_state_nxt;
      r_intr_out <= (w_state_nxt == REQ);
      r_pend     <= w_pend_nxt;
      r_ovr      <= w_ovr_nxt;
      if (r_state == IDLE && w_any) begin
        r_id   <= w_win;
        r_addr <= w_addr;
      end
    end
  end

  assign intr_out  = r_intr_out;
  assign intr_addr = r_addr;
  assign active_id = r_id;
  assign busy      = (r_state != IDLE);
  assign pending   = r_pend;
  assign overrun   = r_ovr;

endmodule

// File: tb/tb_irq_vector_ctrl.sv
// Bench for irq_vector_ctrl: directed scenarios plus random traffic, every
// cycle compared against a cycle-level behavioural model of the controller.
module tb_irq_vector_ctrl;

  localparam int          N      = 8;
  localparam int          SYNC   = 2;
  localparam logic [N-1:0] EM    = 8'hFE;
  localparam logic [N-1:0] AL    = 8'h80;
  localparam logic [31:0] BASE   = 32'h0000_0100;
  localparam logic [31:0] STRIDE = 32'h0000_0010;

  logic         sys_clk = 1'b0;
  logic         ext_rst;
  logic [N-1:0] irq_in, irq_en, ovr_clr;
  logic [1:0]   intr_ack;
  logic         intr_out;
  logic [31:0]  intr_addr;
  logic [2:0]   active_id;
  logic         busy;
  logic [N-1:0] pending, overrun;

  always #5 sys_clk = ~sys_clk;

  irq_vector_ctrl #(
    .N_CH         (N),
    .EDGE_MASK    (EM),
    .ACT_LOW_MASK (AL),
    .VEC_BASE     (BASE),
    .VEC_STRIDE   (STRIDE),
    .SYNC_STAGES  (SYNC)
  ) dut (
    .sys_clk   (sys_clk),
    .ext_rst   (ext_rst),
    .irq_in    (irq_in),
    .irq_en    (irq_en),
    .ovr_clr   (ovr_clr),
    .intr_ack  (intr_ack),
    .intr_out  (intr_out),
    .intr_addr (intr_addr),
    .active_id (active_id),
    .busy      (busy),
    .pending   (pending),
    .overrun   (overrun)
  );

  int n_cmp = 0;
  int n_bad = 0;
  bit chk_en = 1'b0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: actual %h required %h at %0t", nm, act, exp, $time);
    end
  endtask

  // Model: raw sample history, mode 0..3 = idle/request/service/wait-IE.
  logic [N-1:0] hq[$];
  int           mst;
  int           m_id;
  logic [31:0]  m_addr;
  logic [N-1:0] m_pend, m_ovr;

  function automatic void m_reset();
    hq.delete();
    for (int i = 0; i < SYNC + 1; i++) hq.push_back(AL);
    mst    = 0;
    m_id   = 0;
    m_addr = BASE;
    m_pend = '0;
    m_ovr  = '0;
  endfunction

  function automatic void m_step(input logic [N-1:0] xin, input logic [N-1:0] en,
                                 input logic [N-1:0] oc, input logic [1:0] ak);
    logic [N-1:0] lvl, prv, npend, novr, elig;
    bit rise, clr, setv;
    int w;
    // A source sampled at edge t is seen by the pending logic at edge t+SYNC.
    lvl   = hq[1] ^ AL;
    prv   = hq[0] ^ AL;
    npend = m_pend;
    novr  = m_ovr;
    for (int i = 0; i < N; i++) begin
      clr  = (mst == 1) && (ak == 2'b01) && (m_id == i);
      setv = 1'b0;
      if (EM[i]) begin
        rise = lvl[i] && !prv[i];
        if (rise) begin
          setv     = m_pend[i] && !clr;
          npend[i] = 1'b1;
        end else if (clr) npend[i] = 1'b0;
      end else begin
        npend[i] = lvl[i];
      end
      if (setv) novr[i] = 1'b1;
      else if (oc[i]) novr[i] = 1'b0;
    end
    elig = m_pend & en;
    case (mst)
      0: if (elig != 0) begin
           w = 0;
           for (int i = N - 1; i >= 0; i--) if (elig[i]) w = i;
           m_id   = w;
           m_addr = BASE + STRIDE * 32'(w);
           mst    = 1;
         end
      1: if (ak == 2'b01) mst = 2;
      2: if (ak == 2'b10) mst = 3;
      default: if (ak == 2'b11) mst = 0;
    endcase
    m_pend = npend;
    m_ovr  = novr;
    hq.push_back(xin);
    void'(hq.pop_front());
  endfunction

  always @(posedge sys_clk) begin
    if (ext_rst) begin
      m_reset();
      chk_en = 1'b1;
    end else if (chk_en) begin
      m_step(irq_in, irq_en, ovr_clr, intr_ack);
    end
  end

  always @(negedge sys_clk) begin
    if (chk_en) begin
      chk("intr_out",  32'(intr_out),  32'(mst == 1));
      chk("intr_addr", intr_addr,      m_addr);
      chk("active_id", 32'(active_id), 32'(m_id));
      chk("busy",      32'(busy),      32'(mst != 0));
      chk("pending",   32'(pending),   32'(m_pend));
      chk("overrun",   32'(overrun),   32'(m_ovr));
    end
  end

  task automatic tick(input int n = 1);
    repeat (n) @(negedge sys_clk);
  endtask

  task automatic ack(input logic [1:0] v);
    intr_ack = v;
    tick();
    intr_ack = 2'b00;
  endtask

  task automatic full_ack();
    ack(2'b01);
    ack(2'b10);
    ack(2'b11);
  endtask

  task automatic wait_req(input string nm, input int lim);
    int c = 0;
    while (!intr_out && c < lim) begin
      tick();
      c++;
    end
    chk(nm, 32'(intr_out), 32'd1);
  endtask

  initial begin
    logic [1:0] proper;
    irq_in   = AL;
    irq_en   = '1;
    ovr_clr  = '0;
    intr_ack = 2'b00;
    ext_rst  = 1'b1;
    tick(2);
    ext_rst  = 1'b0;
    chk("rst_addr", intr_addr, 32'h0000_0100);
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_pend", 32'(pending), 32'd0);

    // Edge channel 3: request exactly three edges after first sample.
    irq_in[3] = 1'b1;
    tick(3);
    chk("ch3_early", 32'(intr_out), 32'd0);
    tick();
    chk("ch3_req",  32'(intr_out), 32'd1);
    chk("ch3_addr", intr_addr, 32'h0000_0130);
    chk("ch3_id",   32'(active_id), 32'd3);
    irq_in[3] = 1'b0;
    full_ack();
    chk("ch3_pclr", 32'(pending[3]), 32'd0);
    chk("ch3_idle", 32'(busy), 32'd0);

    // Simultaneous rises on 5 and 2, then back-to-back service.
    irq_in[5] = 1'b1;
    irq_in[2] = 1'b1;
    tick(2);
    irq_in[5] = 1'b0;
    irq_in[2] = 1'b0;
    wait_req("ch2_req", 10);
    chk("ch2_addr", intr_addr, 32'h0000_0120);
    full_ack();
    chk("b2b_gap", 32'(intr_out), 32'd0);
    tick();
    chk("b2b_req",  32'(intr_out), 32'd1);
    chk("ch5_addr", intr_addr, 32'h0000_0150);
    chk("ch5_id",   32'(active_id), 32'd5);
    full_ack();
    tick(2);

    // Level channel 0 held, then released before the IE ack.
    irq_in[0] = 1'b1;
    wait_req("lvl_req", 10);
    chk("lvl_addr", intr_addr, 32'h0000_0100);
    full_ack();
    tick();
    chk("lvl_rereq", 32'(intr_out), 32'd1);
    ack(2'b01);
    ack(2'b10);
    irq_in[0] = 1'b0;
    tick(4);
    ack(2'b11);
    tick(6);
    chk("lvl_gone", 32'(busy), 32'd0);

    // Overrun on masked channel 1, clear, and set-wins-over-clear.
    irq_en[1] = 1'b0;
    irq_in[1] = 1'b1; tick(2); irq_in[1] = 1'b0; tick(2);
    irq_in[1] = 1'b1; tick(2); irq_in[1] = 1'b0; tick(3);
    chk("ovr_set",  32'(overrun[1]), 32'd1);
    chk("ovr_pend", 32'(pending[1]), 32'd1);
    ovr_clr[1] = 1'b1; tick(); ovr_clr[1] = 1'b0;
    chk("ovr_clr", 32'(overrun[1]), 32'd0);
    irq_in[1] = 1'b1;
    tick(2);
    ovr_clr[1] = 1'b1; tick(); ovr_clr[1] = 1'b0;
    chk("ovr_wins", 32'(overrun[1]), 32'd1);
    irq_in[1] = 1'b0;
    irq_en[1] = 1'b1;
    wait_req("ch1_req", 10);
    chk("ch1_id", 32'(active_id), 32'd1);
    full_ack();
    ovr_clr[1] = 1'b1; tick(); ovr_clr[1] = 1'b0;
    tick(2);

    // Masked channel 4, enable, then mask drop while requesting.
    irq_en[4] = 1'b0;
    irq_in[4] = 1'b1; tick(2); irq_in[4] = 1'b0;
    tick(6);
    chk("mask_noreq", 32'(intr_out), 32'd0);
    chk("mask_pend",  32'(pending[4]), 32'd1);
    irq_en[4] = 1'b1;
    wait_req("en_req", 4);
    irq_en[4] = 1'b0;
    tick(2);
    chk("frz_id",   32'(active_id), 32'd4);
    chk("frz_addr", intr_addr, 32'h0000_0140);
    ack(2'b01);
    chk("ack_drop", 32'(intr_out), 32'd0);
    ack(2'b10);
    ack(2'b11);
    irq_en[4] = 1'b1;
    tick(2);

    // Spurious acks and reset in SERVICE.
    irq_in[6] = 1'b1; tick(2); irq_in[6] = 1'b0;
    wait_req("ch6_req", 10);
    ack(2'b10);
    chk("spur_req", 32'(intr_out), 32'd1);
    ack(2'b01);
    chk("svc_busy", 32'(busy), 32'd1);
    irq_in[5] = 1'b1; tick(2); irq_in[5] = 1'b0; tick(2);
    ext_rst = 1'b1; tick(); ext_rst = 1'b0;
    chk("mid_rst_out",  32'(intr_out), 32'd0);
    chk("mid_rst_busy", 32'(busy), 32'd0);
    chk("mid_rst_pend", 32'(pending), 32'd0);
    ack(2'b01);
    chk("spur_idle", 32'(busy), 32'd0);

    // Random traffic.
    for (int c = 0; c < 3000; c++) begin
      if ($urandom_range(0, 2) == 0) irq_in = irq_in ^ (8'd1 << $urandom_range(0, 7));
      if ($urandom_range(0, 31) == 0) irq_en = irq_en ^ (8'd1 << $urandom_range(0, 7));
      ovr_clr = ($urandom_range(0, 7) == 0) ? 8'($urandom) : 8'd0;
      proper  = 2'(mst);
      if ($urandom_range(0, 2) == 0)      intr_ack = proper;
      else if ($urandom_range(0, 3) == 0) intr_ack = 2'($urandom);
      else                                intr_ack = 2'b00;
      ext_rst = ($urandom_range(0, 499) == 0);
      tick();
    end
    irq_in   = AL;
    ovr_clr  = '0;
    intr_ack = 2'b00;
    ext_rst  = 1'b0;
    tick(2);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
